food_spawn_gen: RTL and testbench



---
 rtl/food_spawn_gen.sv | 105 ++++++++++
 tb/tb_food_spawn_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/food_spawn_gen.sv
// food_spawn_gen: LFSR-driven fruit placement that rejects off-grid, head, old-fruit and body-occupied cells.
// Define FOOD_AVOID_BORDER_EN to also exclude the outermost ring of grid cells.
module food_spawn_gen #(
    parameter int          CELL_SIZE = 10,
    parameter int          GRID_COLS = 60,
    parameter int          GRID_ROWS = 44,
    parameter int          X_ORIGIN  = 20,
    parameter int          Y_ORIGIN  = 20,
    parameter int          START_X   = 320,
    parameter int          START_Y   = 240,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       spawn_req,
    input  logic [9:0] headX,
    input  logic [9:0] headY,
    output logic       occ_query,
    output logic [9:0] occ_x,
    output logic [9:0] occ_y,
    input  logic       occ_hit,
    output logic [9:0] fruitX,
    output logic [9:0] fruitY,
    output logic       fruit_valid,
    output logic       busy,
    output logic       spawn_fail
);
    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {IDLE, PICK, QUERY, WAIT, COMMIT} state_t;

    state_t        state, state_n;
    logic [15:0]   lfsr;
    logic [TW-1:0] tries;
    logic [5:0]    col, row;
    logic [9:0]    cand_x, cand_y;
    logic          off_grid, clash, reject, last_try;

    assign col    = lfsr[5:0];
    assign row    = lfsr[11:6];
    assign cand_x = 10'(X_ORIGIN + int'(col) * CELL_SIZE);
    assign cand_y = 10'(Y_ORIGIN + int'(row) * CELL_SIZE);

`ifdef FOOD_AVOID_BORDER_EN
    assign off_grid = int'(col) >= GRID_COLS - 1 || int'(row) >= GRID_ROWS - 1 || col == '0 || row == '0;
`else
    assign off_grid = int'(col) >= GRID_COLS || int'(row) >= GRID_ROWS;
`endif

    // occ_x/occ_y hold the candidate under test from PICK until COMMIT
    assign clash     = occ_hit || (occ_x == headX && occ_y == headY) || (occ_x == fruitX && occ_y == fruitY);
    assign reject    = (state == PICK && off_grid) || (state == WAIT && clash);
    assign last_try  = tries == TW'(MAX_TRIES - 1);
    assign occ_query = state == QUERY;
    assign busy      = state != IDLE;

    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = spawn_req ? PICK : IDLE;
            PICK:    state_n = !off_grid ? QUERY : (last_try ? IDLE : PICK);
            QUERY:   state_n = WAIT;
            WAIT:    state_n = !clash ? COMMIT : (last_try ? IDLE : PICK);
            COMMIT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or posedge Reset)
        if (Reset) begin
            lfsr        <= SEED;
            tries       <= '0;
            occ_x       <= '0;
            occ_y       <= '0;
            fruitX      <= 10'(START_X);
            fruitY      <= 10'(START_Y);
            fruit_valid <= 1'b1;
            spawn_fail  <= 1'b0;
        end else begin
            lfsr       <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            spawn_fail <= reject && last_try;
            if (state == IDLE && spawn_req) begin
                tries       <= '0;
                fruit_valid <= 1'b0;
            end
            if (reject)
                tries <= tries + 1'b1;
            if (state == PICK && !off_grid) begin
                occ_x <= cand_x;
                occ_y <= cand_y;
            end
            if (state == COMMIT) begin
                fruitX      <= occ_x;
                fruitY      <= occ_y;
                fruit_valid <= 1'b1;
            end
        end
endmodule

// File: tb/tb_food_spawn_gen.sv
// tb_food_spawn_gen: scoreboard bench for food_spawn_gen against a behavioural spawn model.
module tb_food_spawn_gen;
    localparam int CS = 10, COLS = 60, ROWS = 44, XO = 20, YO = 20, SX = 320, SY = 240, MAXT = 16;
`ifdef FOOD_AVOID_BORDER_EN
    localparam int NRAND = 1000;
`else
    localparam int NRAND = 40;
`endif

    typedef struct {logic [9:0] x, y; int c;} qry_t;
    typedef struct {logic fail; logic [9:0] x, y; int c;} out_t;

    logic       frame_clk = 0, Reset = 1, spawn_req = 0, occ_hit = 0;
    logic [9:0] headX = 0, headY = 0;
    logic       occ_query, fruit_valid, busy, spawn_fail;
    logic [9:0] occ_x, occ_y, fruitX, fruitY;
    int         checks = 0, errors = 0, cyc = 0;
    logic [15:0] m;
    logic [9:0] exp_fx = 10'(SX), exp_fy = 10'(SY);
    qry_t       qq[$];
    out_t       oq[$];
    logic       hq[$];
    bit         exp_busy[int];
    logic       resp = 0, resp_next = 0, prev_fv = 1;
    qry_t       q_mon;
    out_t       o_mon;

    food_spawn_gen dut (
        .frame_clk(frame_clk), .Reset(Reset), .spawn_req(spawn_req),
        .headX(headX), .headY(headY),
        .occ_query(occ_query), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
        .fruitX(fruitX), .fruitY(fruitY), .fruit_valid(fruit_valid),
        .busy(busy), .spawn_fail(spawn_fail)
    );

    always #5 frame_clk = ~frame_clk;

    function automatic logic [15:0] step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit bad(input int c, input int r);
`ifdef FOOD_AVOID_BORDER_EN
        return c <= 0 || r <= 0 || c >= COLS - 1 || r >= ROWS - 1;
`else
        return c >= COLS || r >= ROWS;
`endif
    endfunction

    always @(posedge frame_clk) cyc <= cyc + 1;
    always @(posedge frame_clk or posedge Reset) m <= Reset ? 16'hACE1 : step(m);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Walk the spawn rules for a request accepted at edge n with LFSR value s in the first PICK cycle
    task automatic plan(input int n, input logic [15:0] s, input int hits, output int e, output int qc);
        logic [15:0] l;
        int t, tries, qn, c, r;
        logic [9:0] cx, cy;
        bit hit;
        l = s; t = n; tries = 0; qn = 0; qc = -1; e = 0;
        forever begin
            c = int'(l) % 64;
            r = (int'(l) / 64) % 64;
            if (bad(c, r)) begin
                tries++;
                if (tries == MAXT) begin
                    e = t + 1 - n;
                    oq.push_back('{1'b1, exp_fx, exp_fy, t + 1});
                    break;
                end
                l = step(l);
                t++;
            end else begin
                cx = 10'(XO + c * CS);
                cy = 10'(YO + r * CS);
                qn++;
                hit = qn <= hits;
                if (qc < 0) qc = t + 1;
                qq.push_back('{cx, cy, t + 1});
                hq.push_back(hit);
                if (hit || (cx == headX && cy == headY) || (cx == exp_fx && cy == exp_fy)) begin
                    tries++;
                    if (tries == MAXT) begin
                        e = t + 3 - n;
                        oq.push_back('{1'b1, exp_fx, exp_fy, t + 3});
                        break;
                    end
                    l = step(step(step(l)));
                    t += 3;
                end else begin
                    e = t + 4 - n;
                    oq.push_back('{1'b0, cx, cy, t + 4});
                    exp_fx = cx;
                    exp_fy = cy;
                    break;
                end
            end
        end
        for (int k = n; k < n + e; k++) exp_busy[k] = 1;
    endtask

    function automatic void first_cand(input logic [15:0] s, output logic [9:0] x, output logic [9:0] y);
        logic [15:0] l;
        l = s; x = 0; y = 0;
        for (int i = 0; i < MAXT; i++) begin
            if (!bad(int'(l) % 64, (int'(l) / 64) % 64)) begin
                x = 10'(XO + (int'(l) % 64) * CS);
                y = 10'(YO + ((int'(l) / 64) % 64) * CS);
                return;
            end
            l = step(l);
        end
    endfunction

    task automatic spawn(input int hits, input int hold, input bit abort);
        int n, k, e, qc, qc0, last;
        logic [15:0] s;
        n = cyc + 1; k = n; s = step(m); qc0 = -1; last = n;
        while (k <= n + hold - 1) begin
            plan(k, s, hits, e, qc);
            if (k == n) qc0 = qc;
            last = k + e;
            for (int i = 0; i <= e; i++) s = step(s);
            k = last + 1;
        end
        spawn_req = 1;
        @(negedge frame_clk);
        chk("fv_drop_at_accept", fruit_valid, 0);
        chk("busy_at_accept", busy, 1);
        if (abort && qc0 >= 0) begin
            spawn_req = 0;
            while (cyc < qc0 + 1) @(negedge frame_clk);
            #2 Reset = 1;
            #1;
            chk("abort_occ_query", occ_query, 0);
            chk("abort_busy", busy, 0);
            chk("abort_fruit_valid", fruit_valid, 1);
            chk("abort_fruitX", fruitX, SX);
            chk("abort_fruitY", fruitY, SY);
            chk("abort_spawn_fail", spawn_fail, 0);
            qq.delete(); oq.delete(); hq.delete(); exp_busy.delete();
            exp_fx = 10'(SX); exp_fy = 10'(SY);
            repeat (2) @(negedge frame_clk);
            #2 Reset = 0;
            @(negedge frame_clk);
            return;
        end
        repeat (hold - 1) @(negedge frame_clk);
        spawn_req = 0;
        while (cyc < last) @(negedge frame_clk);
    endtask

    // Body-store emulation: answers each query in the following cycle, random noise otherwise
    always @(negedge frame_clk) begin
        occ_hit = resp_next ? resp : 1'($urandom);
        resp_next = occ_query;
        if (occ_query) resp = hq.size() > 0 ? hq.pop_front() : 1'b0;
    end

    always @(negedge frame_clk) begin
        if (Reset)
            prev_fv <= fruit_valid;
        else begin
            chk("busy", busy, exp_busy.exists(cyc));
            if (occ_query) begin
                if (qq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_query: occ_query=1 with none expected (cycle %0d)", cyc);
                end else begin
                    q_mon = qq.pop_front();
                    chk("occ_x", occ_x, q_mon.x);
                    chk("occ_y", occ_y, q_mon.y);
                    chk("query_cycle", cyc, q_mon.c);
                end
            end
            if (spawn_fail || (fruit_valid && !prev_fv)) begin
                if (oq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: spawn_fail=%0d fruit_valid=%0d with none expected (cycle %0d)", spawn_fail, fruit_valid, cyc);
                end else begin
                    o_mon = oq.pop_front();
                    chk("result_fail_flag", spawn_fail, o_mon.fail);
                    chk("result_cycle", cyc, o_mon.c);
                    chk("fruitX", fruitX, o_mon.x);
                    chk("fruitY", fruitY, o_mon.y);
                    chk("fruit_valid", fruit_valid, !o_mon.fail);
                    if (!spawn_fail) begin
                        chk("x_on_grid", (int'(fruitX) - XO) % CS, 0);
                        chk("y_on_grid", (int'(fruitY) - YO) % CS, 0);
                        chk("x_in_range", int'(fruitX) <= XO + (COLS - 1) * CS, 1);
                        chk("y_in_range", int'(fruitY) <= YO + (ROWS - 1) * CS, 1);
`ifdef FOOD_AVOID_BORDER_EN
                        chk("x_not_border", int'(fruitX) != XO && int'(fruitX) != XO + (COLS - 1) * CS, 1);
                        chk("y_not_border", int'(fruitY) != YO && int'(fruitY) != YO + (ROWS - 1) * CS, 1);
`endif
                    end
                end
            end
            prev_fv <= fruit_valid;
        end
    end

    initial begin
        logic [9:0] hx, hy;
        repeat (3) @(negedge frame_clk);
        Reset = 0;
        #1;
        chk("rst_fruitX", fruitX, SX);
        chk("rst_fruitY", fruitY, SY);
        chk("rst_fruit_valid", fruit_valid, 1);
        chk("rst_busy", busy, 0);
        chk("rst_occ_query", occ_query, 0);
        chk("rst_spawn_fail", spawn_fail, 0);
        @(negedge frame_clk);
        spawn(0, 1, 0);
        repeat (2) @(negedge frame_clk);
        spawn(3, 1, 0);
        spawn(1000, 1, 0);
        spawn(0, 20, 0);
        spawn(0, 1, 1);
        for (int i = 0; i < NRAND; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge frame_clk);
            if ($urandom_range(0, 3) == 0) begin
                first_cand(step(m), hx, hy);
                headX = hx;
                headY = hy;
            end else begin
                headX = 10'($urandom_range(0, 1023));
                headY = 10'($urandom_range(0, 1023));
            end
            spawn($urandom_range(0, 15) == 0 ? 1000 : $urandom_range(0, 2), $urandom_range(1, 8), 0);
        end
        repeat (5) @(negedge frame_clk);
        chk("queries_drained", qq.size(), 0);
        chk("results_drained", oq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
